// File: rtl/pll_lock_ctrl.sv
// rtl/pll_lock_ctrl.sv - acquisition/lock sequencer for the QPSK carrier PLL
// Optional lock statistics ports are added when PLL_LOCK_STATS_EN is defined.
module pll_lock_ctrl #(
    parameter int WIN_LOG2    = 4,
    parameter int FLUSH_CYC   = 16,
    parameter int LOCK_WINS   = 4,
    parameter int UNLOCK_WINS = 2,
    parameter int ACQ_TO_WINS = 64,
    parameter int MAX_RETRY   = 3
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_enable,
    input  logic               i_err_vld,
    input  logic signed [15:0] i_err,
    input  logic [15:0]        i_lock_thr,
    input  logic [15:0]        i_unlock_thr,
`ifdef PLL_LOCK_STATS_EN
    output logic [15:0]        o_unlock_cnt,
    output logic [31:0]        o_acq_cycles,
`endif
    output logic               o_pll_rst_n,
    output logic               o_track_mode,
    output logic               o_locked,
    output logic [2:0]         o_state,
    output logic [15:0]        o_win_avg,
    output logic               o_win_vld
);
    localparam int ACW = 16 + WIN_LOG2;
    localparam int FLW = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;
    localparam int GW  = $clog2(LOCK_WINS + 1);
    localparam int BW  = $clog2(UNLOCK_WINS + 1);
    localparam int TW  = $clog2(ACQ_TO_WINS + 1);
    localparam int RW  = $clog2(MAX_RETRY + 2);

    localparam logic [FLW-1:0] FLUSH_LAST = FLW'(FLUSH_CYC - 1);
    localparam logic [GW-1:0]  LOCK_C     = GW'(LOCK_WINS);
    localparam logic [BW-1:0]  UNLOCK_C   = BW'(UNLOCK_WINS);
    localparam logic [TW-1:0]  TO_C       = TW'(ACQ_TO_WINS);
    localparam logic [RW-1:0]  MAXR_C     = RW'(MAX_RETRY);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FLUSH = 3'd1,
        S_ACQ   = 3'd2,
        S_TRACK = 3'd3,
        S_FAIL  = 3'd4
    } state_t;

    state_t              state_q;
    logic                pll_rst_n_q;
    logic                track_q;
    logic                locked_q;
    logic [15:0]         win_avg_q;
    logic                win_vld_q;
    logic [FLW-1:0]      flush_cnt_q;
    logic [WIN_LOG2-1:0] smp_cnt_q;
    logic [ACW-1:0]      acc_q;
    logic [GW-1:0]       good_q;
    logic [BW-1:0]       bad_q;
    logic [TW-1:0]       win_cnt_q;
    logic [RW-1:0]       retry_q;

    logic [15:0]         err_u;
    logic [15:0]         err_abs_d;
    logic                take_d;
    logic                win_last_d;
    logic [ACW-1:0]      acc_sum_d;
    logic [GW-1:0]       good_nxt_d;
    logic [BW-1:0]       bad_nxt_d;
    logic [TW-1:0]       win_cnt_inc_d;
    logic [RW-1:0]       retry_inc_d;

    assign err_u = i_err;

    // -32768 has no positive twin in 16 bits, so it clamps rather than wraps
    always_comb begin
        err_abs_d     = err_u[15] ? 16'(~err_u + 16'd1) : err_u;
        if (err_u == 16'h8000) begin
            err_abs_d = 16'h7fff;
        end
        take_d        = i_err_vld && ((state_q == S_ACQ) || (state_q == S_TRACK));
        win_last_d    = take_d && (smp_cnt_q == {WIN_LOG2{1'b1}});
        acc_sum_d     = acc_q + ACW'(err_abs_d);
        good_nxt_d    = (win_avg_q < i_lock_thr)   ? good_q + GW'(1) : '0;
        bad_nxt_d     = (win_avg_q > i_unlock_thr) ? bad_q + BW'(1)  : '0;
        win_cnt_inc_d = win_cnt_q + TW'(1);
        retry_inc_d   = retry_q + RW'(1);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= S_IDLE;
            pll_rst_n_q <= 1'b0;
            track_q     <= 1'b0;
            locked_q    <= 1'b0;
            win_avg_q   <= '0;
            win_vld_q   <= 1'b0;
            flush_cnt_q <= '0;
            smp_cnt_q   <= '0;
            acc_q       <= '0;
            good_q      <= '0;
            bad_q       <= '0;
            win_cnt_q   <= '0;
            retry_q     <= '0;
        end else if (!i_enable) begin
            state_q     <= S_IDLE;
            pll_rst_n_q <= 1'b0;
            track_q     <= 1'b0;
            locked_q    <= 1'b0;
            win_vld_q   <= 1'b0;
            flush_cnt_q <= '0;
            smp_cnt_q   <= '0;
            acc_q       <= '0;
            good_q      <= '0;
            bad_q       <= '0;
            win_cnt_q   <= '0;
            retry_q     <= '0;
        end else begin
            win_vld_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    state_q     <= S_FLUSH;
                    retry_q     <= '0;
                    flush_cnt_q <= '0;
                end
                S_FLUSH: begin
                    smp_cnt_q <= '0;
                    acc_q     <= '0;
                    good_q    <= '0;
                    bad_q     <= '0;
                    win_cnt_q <= '0;
                    if (flush_cnt_q == FLUSH_LAST) begin
                        state_q     <= S_ACQ;
                        pll_rst_n_q <= 1'b1;
                        flush_cnt_q <= '0;
                    end else begin
                        flush_cnt_q <= flush_cnt_q + FLW'(1);
                    end
                end
                S_ACQ, S_TRACK: begin
                    if (take_d) begin
                        if (win_last_d) begin
                            win_avg_q <= acc_sum_d[ACW-1:WIN_LOG2];
                            win_vld_q <= 1'b1;
                            acc_q     <= '0;
                            smp_cnt_q <= '0;
                        end else begin
                            acc_q     <= acc_sum_d;
                            smp_cnt_q <= smp_cnt_q + WIN_LOG2'(1);
                        end
                    end
                    // Evaluation runs on the cycle the new average is presented
                    if (win_vld_q && (state_q == S_ACQ)) begin
                        good_q    <= good_nxt_d;
                        win_cnt_q <= win_cnt_inc_d;
                        if (good_nxt_d == LOCK_C) begin
                            state_q  <= S_TRACK;
                            track_q  <= 1'b1;
                            locked_q <= 1'b1;
                            retry_q  <= '0;
                            bad_q    <= '0;
                        end else if (win_cnt_inc_d == TO_C) begin
                            retry_q     <= retry_inc_d;
                            pll_rst_n_q <= 1'b0;
                            flush_cnt_q <= '0;
                            state_q     <= (retry_inc_d <= MAXR_C) ? S_FLUSH : S_FAIL;
                        end
                    end else if (win_vld_q) begin
                        bad_q <= bad_nxt_d;
                        if (bad_nxt_d == UNLOCK_C) begin
                            state_q     <= S_FLUSH;
                            flush_cnt_q <= '0;
                            pll_rst_n_q <= 1'b0;
                            track_q     <= 1'b0;
                            locked_q    <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q     <= S_FAIL;
                    pll_rst_n_q <= 1'b0;
                    track_q     <= 1'b0;
                    locked_q    <= 1'b0;
                end
            endcase
        end
    end

    assign o_pll_rst_n  = pll_rst_n_q;
    assign o_track_mode = track_q;
    assign o_locked     = locked_q;
    assign o_state      = state_q;
    assign o_win_avg    = win_avg_q;
    assign o_win_vld    = win_vld_q;

`ifdef PLL_LOCK_STATS_EN
    state_t      prev_q;
    logic [15:0] unlock_cnt_q;
    logic [31:0] acq_run_q;
    logic [31:0] acq_cycles_q;

    // Transitions are seen one clock late via prev_q; only i_rst_n clears these
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            prev_q       <= S_IDLE;
            unlock_cnt_q <= '0;
            acq_run_q    <= '0;
            acq_cycles_q <= '0;
        end else begin
            prev_q <= state_q;
            if (state_q != S_ACQ) begin
                acq_run_q <= '0;
            end else if (acq_run_q != '1) begin
                acq_run_q <= acq_run_q + 32'd1;
            end
            if ((state_q == S_TRACK) && (prev_q == S_ACQ)) begin
                acq_cycles_q <= acq_run_q;
            end
            if ((state_q == S_FLUSH) && (prev_q == S_TRACK) && (unlock_cnt_q != '1)) begin
                unlock_cnt_q <= unlock_cnt_q + 16'd1;
            end
        end
    end

    assign o_unlock_cnt = unlock_cnt_q;
    assign o_acq_cycles = acq_cycles_q;
`endif

endmodule

// File: tb/tb_pll_lock_ctrl.sv
// tb/tb_pll_lock_ctrl.sv - directed self-checking bench for pll_lock_ctrl
module tb_pll_lock_ctrl;
    logic               clk = 1'b0;
    logic               rst_n;
    logic               enable;
    logic               err_vld;
    logic signed [15:0] err;
    logic [15:0]        lock_thr;
    logic [15:0]        unlock_thr;
    logic               pll_rst_n;
    logic               track_mode;
    logic               locked;
    logic [2:0]         state;
    logic [15:0]        win_avg;
    logic               win_vld;
`ifdef PLL_LOCK_STATS_EN
    logic [15:0]        unlock_cnt;
    logic [31:0]        acq_cycles;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pll_lock_ctrl dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_enable     (enable),
        .i_err_vld    (err_vld),
        .i_err        (err),
        .i_lock_thr   (lock_thr),
        .i_unlock_thr (unlock_thr),
`ifdef PLL_LOCK_STATS_EN
        .o_unlock_cnt (unlock_cnt),
        .o_acq_cycles (acq_cycles),
`endif
        .o_pll_rst_n  (pll_rst_n),
        .o_track_mode (track_mode),
        .o_locked     (locked),
        .o_state      (state),
        .o_win_avg    (win_avg),
        .o_win_vld    (win_vld)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_state(input logic [2:0] s, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            if (state == s) ok = 1'b1;
            else tick();
        end
        if (state == s) ok = 1'b1;
    endtask

    task automatic wait_win(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            tick();
            if (win_vld) ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; enable = 1'b0; err_vld = 1'b0; err = '0;
        lock_thr = 16'd100; unlock_thr = 16'd200;
        repeat (3) tick();
        total++; if (state !== 3'd0)    begin bad++; $display("FAIL reset_state got=%0d exp=0", state); end
        total++; if (pll_rst_n !== 1'b0) begin bad++; $display("FAIL reset_pll_rst_n got=%b exp=0", pll_rst_n); end
        total++; if (track_mode !== 1'b0) begin bad++; $display("FAIL reset_track got=%b exp=0", track_mode); end
        total++; if (locked !== 1'b0)   begin bad++; $display("FAIL reset_locked got=%b exp=0", locked); end
        total++; if (win_avg !== 16'd0) begin bad++; $display("FAIL reset_win_avg got=%0d exp=0", win_avg); end
        total++; if (win_vld !== 1'b0)  begin bad++; $display("FAIL reset_win_vld got=%b exp=0", win_vld); end
        rst_n = 1'b1;
        tick();
        total++; if (state !== 3'd0) begin bad++; $display("FAIL idle_disabled got=%0d exp=0", state); end
    endtask

    task automatic test_lock();
        int n_flush = 0;
        int n_acq = 0;
        int n_flush_rel = 0;
        err = 16'sd20; err_vld = 1'b1; enable = 1'b1;
        for (int i = 0; i < 400 && state != 3'd3; i++) begin
            tick();
            if (state == 3'd1) begin
                n_flush++;
                if (pll_rst_n) n_flush_rel++;
            end
            if (state == 3'd2) n_acq++;
        end
        total++; if (state !== 3'd3) begin bad++; $display("FAIL lock_state got=%0d exp=3", state); end
        total++; if (n_flush != 16) begin bad++; $display("FAIL flush_len got=%0d exp=16", n_flush); end
        total++; if (n_flush_rel != 0) begin bad++; $display("FAIL flush_pll_rst got=%0d exp=0", n_flush_rel); end
        total++; if (n_acq != 65) begin bad++; $display("FAIL acq_len got=%0d exp=65", n_acq); end
        total++; if (win_avg !== 16'd20) begin bad++; $display("FAIL lock_avg got=%0d exp=20", win_avg); end
        total++; if (locked !== 1'b1) begin bad++; $display("FAIL lock_locked got=%b exp=1", locked); end
        total++; if (track_mode !== 1'b1) begin bad++; $display("FAIL lock_track got=%b exp=1", track_mode); end
        total++; if (pll_rst_n !== 1'b1) begin bad++; $display("FAIL lock_pll_rst_n got=%b exp=1", pll_rst_n); end
`ifdef PLL_LOCK_STATS_EN
        tick(); tick();
        total++; if (acq_cycles !== 32'(n_acq)) begin bad++; $display("FAIL acq_cycles got=%0d exp=%0d", acq_cycles, n_acq); end
`endif
    endtask

    task automatic test_unlock();
        bit ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            if (state == 3'd1) ok = 1'b1;
            else begin
                err = (err == 16'sd500) ? -16'sd500 : 16'sd500;
                tick();
            end
        end
        total++; if (!ok) begin bad++; $display("FAIL unlock_timeout state=%0d exp=1", state); end
        total++; if (locked !== 1'b0) begin bad++; $display("FAIL unlock_locked got=%b exp=0", locked); end
        total++; if (pll_rst_n !== 1'b0) begin bad++; $display("FAIL unlock_pll_rst_n got=%b exp=0", pll_rst_n); end
        total++; if (track_mode !== 1'b0) begin bad++; $display("FAIL unlock_track got=%b exp=0", track_mode); end
        total++; if (win_avg !== 16'd500) begin bad++; $display("FAIL unlock_avg got=%0d exp=500", win_avg); end
    endtask

    task automatic test_timeout();
        int n_to = 0;
        logic [2:0] prev;
        err = 16'sd1000;
        prev = state;
        for (int i = 0; i < 6000 && state != 3'd4; i++) begin
            tick();
            if (prev == 3'd2 && state == 3'd1) n_to++;
            prev = state;
        end
        total++; if (state !== 3'd4) begin bad++; $display("FAIL fail_state got=%0d exp=4", state); end
        total++; if (n_to != 3) begin bad++; $display("FAIL retry_flushes got=%0d exp=3", n_to); end
        total++; if (pll_rst_n !== 1'b0) begin bad++; $display("FAIL fail_pll_rst_n got=%b exp=0", pll_rst_n); end
        repeat (40) tick();
        total++; if (state !== 3'd4) begin bad++; $display("FAIL fail_sticky got=%0d exp=4", state); end
        enable = 1'b0;
        tick();
        total++; if (state !== 3'd0) begin bad++; $display("FAIL disable_idle got=%0d exp=0", state); end
        total++; if (pll_rst_n !== 1'b0) begin bad++; $display("FAIL idle_pll_rst_n got=%b exp=0", pll_rst_n); end
    endtask

    task automatic test_saturate();
        bit ok;
        err = -16'sd32768; enable = 1'b1;
        wait_win(100, ok);
        total++; if (!ok) begin bad++; $display("FAIL sat_win_timeout got=0 exp=1"); end
        total++; if (win_avg !== 16'd32767) begin bad++; $display("FAIL sat_avg got=%0d exp=32767", win_avg); end
        total++; if (state !== 3'd2) begin bad++; $display("FAIL sat_state got=%0d exp=2", state); end
    endtask

    task automatic test_thr_equal();
        bit ok;
        bit all_ok = 1'b1;
        err = 16'sd100; lock_thr = 16'd100;
        for (int w = 0; w < 6; w++) begin
            wait_win(40, ok);
            all_ok &= ok;
        end
        tick();
        total++; if (!all_ok) begin bad++; $display("FAIL eq_win_timeout got=0 exp=1"); end
        total++; if (state !== 3'd2) begin bad++; $display("FAIL eq_lock_thr_state got=%0d exp=2", state); end
        total++; if (win_avg !== 16'd100) begin bad++; $display("FAIL eq_avg got=%0d exp=100", win_avg); end
        lock_thr = 16'd101;
        wait_state(3'd3, 120, ok);
        total++; if (!ok) begin bad++; $display("FAIL above_thr_lock got=%0d exp=3", state); end
        unlock_thr = 16'd100;
        all_ok = 1'b1;
        for (int w = 0; w < 4; w++) begin
            wait_win(40, ok);
            all_ok &= ok;
        end
        tick();
        total++; if (!all_ok || state !== 3'd3) begin bad++; $display("FAIL eq_unlock_thr_state got=%0d exp=3", state); end
        total++; if (locked !== 1'b1) begin bad++; $display("FAIL eq_unlock_locked got=%b exp=1", locked); end
    endtask

    task automatic test_reset_mid();
        bit ok;
        err = 16'sd1000;
        repeat (5) tick();
        rst_n = 1'b0;
        #1;
        total++; if (state !== 3'd0) begin bad++; $display("FAIL midrst_state got=%0d exp=0", state); end
        total++; if (locked !== 1'b0) begin bad++; $display("FAIL midrst_locked got=%b exp=0", locked); end
        total++; if (pll_rst_n !== 1'b0) begin bad++; $display("FAIL midrst_pll_rst_n got=%b exp=0", pll_rst_n); end
        total++; if (track_mode !== 1'b0) begin bad++; $display("FAIL midrst_track got=%b exp=0", track_mode); end
        total++; if (win_avg !== 16'd0) begin bad++; $display("FAIL midrst_avg got=%0d exp=0", win_avg); end
`ifdef PLL_LOCK_STATS_EN
        total++; if (unlock_cnt !== 16'd0) begin bad++; $display("FAIL midrst_unlock_cnt got=%0d exp=0", unlock_cnt); end
`endif
        tick();
        rst_n = 1'b1; err = 16'sd20; lock_thr = 16'd100; unlock_thr = 16'd200;
        wait_win(60, ok);
        total++; if (!ok) begin bad++; $display("FAIL midrst_win_timeout got=0 exp=1"); end
        total++; if (win_avg !== 16'd20) begin bad++; $display("FAIL midrst_first_avg got=%0d exp=20", win_avg); end
        total++; if (state !== 3'd2) begin bad++; $display("FAIL midrst_acq got=%0d exp=2", state); end
    endtask

`ifdef PLL_LOCK_STATS_EN
    task automatic test_stats();
        int n_acq;
        bit ok;
        for (int c = 0; c < 2; c++) begin
            n_acq = 0;
            err = 16'sd20;
            for (int i = 0; i < 400 && state != 3'd3; i++) begin
                tick();
                if (state == 3'd2) n_acq++;
            end
            tick(); tick();
            if (c == 1) begin
                total++; if (acq_cycles !== 32'(n_acq)) begin bad++; $display("FAIL stats_acq got=%0d exp=%0d", acq_cycles, n_acq); end
            end
            ok = 1'b0;
            for (int i = 0; i < 200 && !ok; i++) begin
                if (state == 3'd1) ok = 1'b1;
                else begin
                    err = (err == 16'sd500) ? -16'sd500 : 16'sd500;
                    tick();
                end
            end
        end
        tick(); tick();
        total++; if (unlock_cnt !== 16'd2) begin bad++; $display("FAIL stats_unlock_cnt got=%0d exp=2", unlock_cnt); end
    endtask
`endif

    initial begin
        test_reset();
        test_lock();
        test_unlock();
        test_timeout();
        test_saturate();
        test_thr_equal();
        test_reset_mid();
`ifdef PLL_LOCK_STATS_EN
        test_stats();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
